// File: rtl/lsu_align_seq.sv
// Load/store sequencer in front of dmem: word-only reads with local split/merge and
// extension of unaligned loads, single-cycle stores, and error responses for bad requests.
module lsu_align_seq #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RDA   | reading the word holding the first byte
    // RDB   | reading the following word of a crossing load
    // WR    | one-cycle dmem write
    // RESP  | response pulse, no error
    // ERR   | response pulse, error
    typedef enum logic [2:0] {IDLE, RDA, RDB, WR, RESP, ERR} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  memop_q, memop_d;
    logic        we_q, we_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] w1_q, w1_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [2:0]  mem_memop_q, mem_memop_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        req_illegal;
    logic        req_misal;
    logic [2:0]  size_q;
    logic        crossing;
    logic [31:0] word_addr;
    logic [63:0] merged;
    logic [31:0] raw;
    logic [31:0] load_res;

    assign req_illegal = (req_memop == 3'b011) || (req_memop[2:1] == 2'b11) ||
                         (req_we && req_memop[2]);
    assign req_misal   = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign size_q    = (memop_q[1:0] == 2'b00) ? 3'd1 :
                       (memop_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign crossing  = ({1'b0, addr_q[1:0]} + size_q) > 3'd4;
    assign word_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            addr_q      <= 32'd0;
            memop_q     <= 3'b010;
            we_q        <= 1'b0;
            w0_q        <= 32'd0;
            w1_q        <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_memop_q <= 3'b010;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            memop_q     <= memop_d;
            we_q        <= we_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            mem_addr_q  <= mem_addr_d;
            mem_memop_q <= mem_memop_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        memop_d     = memop_q;
        we_d        = we_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        mem_addr_d  = mem_addr_q;
        mem_memop_d = mem_memop_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    memop_d = req_memop;
                    we_d    = req_we;
                    if (req_illegal || (req_we && req_misal)) begin
                        state_d = ERR;
                    end else if (req_we) begin
                        state_d     = WR;
                        mem_addr_d  = req_addr;
                        mem_memop_d = req_memop;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d     = RDA;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_memop_d = 3'b010;
                        lat_cnt_d   = LAT_INIT;
                    end
                end
            end
            RDA: begin
                if (lat_cnt_q == 2'd0) begin
                    w0_d = mem_rdata;
                    if (crossing) begin
                        state_d    = RDB;
                        mem_addr_d = word_addr + 32'd4;
                        lat_cnt_d  = LAT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            RDB: begin
                if (lat_cnt_q == 2'd0) begin
                    w1_d    = mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            WR:       state_d = RESP;
            RESP,
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Non-crossing loads only use the low bytes after the shift, so a stale w1 is harmless.
    assign merged = {w1_q, w0_q} >> {addr_q[1:0], 3'b000};
    assign raw    = merged[31:0];

    always_comb begin
        load_res = raw;
        unique case (memop_q)
            3'b000:  load_res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_res = {24'd0, raw[7:0]};
            3'b101:  load_res = {16'd0, raw[15:0]};
            default: load_res = raw;
        endcase
    end

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign resp_valid = (state_q == RESP) || (state_q == ERR);
    assign resp_err   = (state_q == ERR);
    assign resp_rdata = ((state_q == RESP) && !we_q) ? load_res : 32'd0;
    assign mem_we     = (state_q == WR);
    assign mem_addr   = mem_addr_q;
    assign mem_memop  = mem_memop_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align_seq.sv
// Bench for lsu_align_seq: two instances (RD_LAT 1 and 3) against a byte-level reference
// model, with directed requests carrying hand-computed results.
module tb_lsu_align_seq;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] req_addr  [NI];
    logic [2:0]  req_memop [NI];
    logic        req_we    [NI];
    logic [31:0] req_wdata [NI];
    logic        resp_valid[NI];
    logic [31:0] resp_rdata[NI];
    logic        resp_err  [NI];
    logic [31:0] mem_addr  [NI];
    logic [2:0]  mem_memop [NI];
    logic        mem_we    [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic [31:0] apipe     [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scoreboard, one entry per instance
    bit          pend   [NI];
    int          acc    [NI];
    int          rcyc   [NI];
    bit          e_err  [NI];
    bit          e_st   [NI];
    bit          e_cross[NI];
    logic [31:0] e_rd   [NI];
    logic [31:0] e_addr [NI];
    logic [2:0]  e_op   [NI];
    logic [31:0] e_wd   [NI];
    // observed responses
    bit          got      [NI];
    logic [31:0] last_rd  [NI];
    logic        last_err [NI];
    int          last_lat [NI];
    int          we_cnt   [NI];
    logic [31:0] we_addr  [NI];
    logic [2:0]  we_op    [NI];

    always #5 clk = ~clk;

    lsu_align_seq #(.RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_memop(req_memop[0]), .req_we(req_we[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .mem_addr(mem_addr[0]), .mem_memop(mem_memop[0]), .mem_we(mem_we[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    lsu_align_seq #(.RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_memop(req_memop[1]), .req_we(req_we[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .mem_addr(mem_addr[1]), .mem_memop(mem_memop[1]), .mem_we(mem_we[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h80FF7F01;
            32'h0000_0200: return 32'h44332211;
            32'h0000_0204: return 32'h88776655;
            32'hFFFF_FFFC: return 32'hA1B2C3D4;
            32'h0000_0000: return 32'h5566F0E1;
            default:       return 32'h0;
        endcase
    endfunction

    // dmem stand-in: data appears RD_LAT cycles after the address is first held
    always @(posedge clk) begin
        apipe[0] <= mem_addr[1];
        apipe[1] <= apipe[0];
    end
    assign mem_rdata[0] = rom(mem_addr[0]);
    assign mem_rdata[1] = rom(apipe[1]);

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = rom({a[31:2], 2'b00}) >> (8 * int'(a[1:0]));
        return w[7:0];
    endfunction

    function automatic int nbytes(input logic [2:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] v;
        int n;
        n = nbytes(op);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_byte(a + 32'(i))) << (8 * i));
        if (n < 4 && !op[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic chk(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // model update at each accept edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                pend[k] = 1'b0;
            end else if (req_valid[k] && req_ready[k]) begin
                logic [31:0] a;
                logic [2:0]  op;
                int lat, n;
                a  = req_addr[k];
                op = req_memop[k];
                n  = nbytes(op);
                pend[k]    = 1'b1;
                acc[k]     = cyc;
                e_addr[k]  = a;
                e_op[k]    = op;
                e_wd[k]    = req_wdata[k];
                e_st[k]    = req_we[k];
                e_cross[k] = (int'(a[1:0]) + n) > 4;
                e_rd[k]    = 32'd0;
                e_err[k]   = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) ||
                             (req_we[k] && (op[2] || (n == 2 && a[0]) ||
                                            (n == 4 && a[1:0] != 2'b00)));
                if (e_err[k])       lat = 1;
                else if (req_we[k]) lat = 2;
                else begin
                    e_rd[k] = load_val(a, op);
                    lat = e_cross[k] ? 2 * lat_of(k) + 1 : lat_of(k) + 1;
                end
                rcyc[k] = cyc + lat - 1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                pend[k] = 1'b0;
                chk(k, "rst_resp_valid", 32'(resp_valid[k]), 32'd0);
                chk(k, "rst_mem_we", 32'(mem_we[k]), 32'd0);
                chk(k, "rst_req_ready", 32'(req_ready[k]), 32'd0);
            end else begin
                logic erv, ewe, lda;
                int L;
                L   = lat_of(k);
                erv = pend[k] && (cyc == rcyc[k]);
                ewe = pend[k] && e_st[k] && !e_err[k] && (cyc == acc[k]);
                lda = pend[k] && !e_st[k] && !e_err[k];
                chk(k, "resp_valid", 32'(resp_valid[k]), 32'(erv));
                if (erv) begin
                    chk(k, "resp_rdata", resp_rdata[k], e_rd[k]);
                    chk(k, "resp_err", 32'(resp_err[k]), 32'(e_err[k]));
                end
                chk(k, "mem_we", 32'(mem_we[k]), 32'(ewe));
                if (ewe) begin
                    chk(k, "wr_addr", mem_addr[k], e_addr[k]);
                    chk(k, "wr_memop", 32'(mem_memop[k]), 32'(e_op[k]));
                    chk(k, "wr_wdata", mem_wdata[k], e_wd[k]);
                end
                if (lda && cyc >= acc[k] && cyc < acc[k] + L) begin
                    chk(k, "rda_addr", mem_addr[k], {e_addr[k][31:2], 2'b00});
                    chk(k, "rd_memop", 32'(mem_memop[k]), 32'h2);
                end else if (lda && e_cross[k] && cyc >= acc[k] + L && cyc < acc[k] + 2 * L) begin
                    chk(k, "rdb_addr", mem_addr[k], {e_addr[k][31:2], 2'b00} + 32'd4);
                    chk(k, "rd_memop", 32'(mem_memop[k]), 32'h2);
                end
                chk(k, "req_ready", 32'(req_ready[k]), 32'(!pend[k]));
                if (mem_we[k]) begin
                    we_cnt[k]++;
                    we_addr[k] = mem_addr[k];
                    we_op[k]   = mem_memop[k];
                end
                if (resp_valid[k]) begin
                    got[k]      = 1'b1;
                    last_rd[k]  = resp_rdata[k];
                    last_err[k] = resp_err[k];
                    last_lat[k] = pend[k] ? cyc - acc[k] + 1 : -1;
                end
                if (erv) pend[k] = 1'b0;
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] a, input logic [2:0] op,
                         input logic we, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        got[k] = 1'b0;
        if (!req_ready[k]) begin
            chk(k, "issue_ready_timeout", 32'(req_ready[k]), 32'd1);
            return;
        end
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_memop[k] = op;
        req_we[k]    = we;
        req_wdata[k] = d;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
    endtask

    task automatic do_req(input int k, input string name, input logic [31:0] a,
                          input logic [2:0] op, input logic we, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int n, w0;
        w0 = we_cnt[k];
        issue(k, a, op, we, d);
        n = 0;
        while (pend[k] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(k, {name, "_seen"}, 32'(got[k]), 32'd1);
        chk(k, {name, "_rdata"}, last_rd[k], exp_rd);
        chk(k, {name, "_err"}, 32'(last_err[k]), 32'(exp_err));
        chk(k, {name, "_lat"}, 32'(last_lat[k]), 32'(exp_lat));
        chk(k, {name, "_wecnt"}, 32'(we_cnt[k] - w0), (we && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_memop[k] = 3'b010;
            req_we[k]    = 1'b0;
            req_wdata[k] = 32'd0;
            we_cnt[k]    = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk(k, "reset_ready", 32'(req_ready[k]), 32'd0);
            chk(k, "reset_rdata", resp_rdata[k], 32'd0);
            chk(k, "reset_err", 32'(resp_err[k]), 32'd0);
            chk(k, "reset_addr", mem_addr[k], 32'd0);
            chk(k, "reset_memop", 32'(mem_memop[k]), 32'h2);
            chk(k, "reset_wdata", mem_wdata[k], 32'd0);
        end
        #1 rst_n = 1'b1;

        do_req(0, "lb_102",  32'h102, 3'b000, 1'b0, 0, 32'hFFFFFFFF, 1'b0, 2);
        do_req(0, "lbu_102", 32'h102, 3'b100, 1'b0, 0, 32'h000000FF, 1'b0, 2);
        do_req(0, "lh_102",  32'h102, 3'b001, 1'b0, 0, 32'hFFFF80FF, 1'b0, 2);
        do_req(0, "lw_201",  32'h201, 3'b010, 1'b0, 0, 32'h55443322, 1'b0, 3);
        do_req(0, "lhu_203", 32'h203, 3'b101, 1'b0, 0, 32'h00005544, 1'b0, 3);
        do_req(0, "lw_100",  32'h100, 3'b010, 1'b0, 0, 32'h80FF7F01, 1'b0, 2);

        do_req(0, "sw_300", 32'h300, 3'b010, 1'b1, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        chk(0, "sw_300_addr", we_addr[0], 32'h300);
        chk(0, "sw_300_op", 32'(we_op[0]), 32'h2);
        do_req(0, "sb_305", 32'h305, 3'b000, 1'b1, 32'h000000AB, 32'd0, 1'b0, 2);
        chk(0, "sb_305_addr", we_addr[0], 32'h305);
        chk(0, "sb_305_op", 32'(we_op[0]), 32'h0);

        do_req(0, "sw_302",   32'h302, 3'b010, 1'b1, 32'h1234, 32'd0, 1'b1, 1);
        do_req(0, "sh_301",   32'h301, 3'b001, 1'b1, 32'h1234, 32'd0, 1'b1, 1);
        do_req(0, "ld_op011", 32'h200, 3'b011, 1'b0, 32'h0,    32'd0, 1'b1, 1);
        do_req(0, "st_op100", 32'h200, 3'b100, 1'b1, 32'h55,   32'd0, 1'b1, 1);

        do_req(0, "lw_wrap", 32'hFFFFFFFE, 3'b010, 1'b0, 0, 32'hF0E1A1B2, 1'b0, 3);
        do_req(1, "lw_201_l3",  32'h201, 3'b010, 1'b0, 0, 32'h55443322, 1'b0, 7);
        do_req(1, "lh_102_l3",  32'h102, 3'b001, 1'b0, 0, 32'hFFFF80FF, 1'b0, 4);
        do_req(1, "sw_302_l3",  32'h302, 3'b010, 1'b1, 32'h1, 32'd0, 1'b1, 1);

        // reset while the crossing load sits in its second read
        issue(0, 32'h201, 3'b010, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk(0, "post_rst_ready", 32'(req_ready[0]), 32'd1);
        chk(0, "post_rst_no_resp", 32'(got[0]), 32'd0);
        chk(0, "post_rst_we", 32'(mem_we[0]), 32'd0);
        do_req(0, "lw_204", 32'h204, 3'b010, 1'b0, 0, 32'h88776655, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
